mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 54 +++++
 rtl/mc_ctrl_decode.sv | 64 ++++++
 rtl/mc_ctrl.sv | 114 +++++++++++
 tb/tb_mc_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes,
// and the packed control word produced by the state decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R_FORM = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_ADDI   = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // Last state of every legal instruction; leaving one of these retires it.
    function automatic logic is_terminal(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_BRANCH) || (s == S_JUMP) || (s == S_ADDIWB);
    endfunction

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_R_FORM) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word table for the multi-cycle controller.
// i_mem_ready gates the FETCH-cycle IR/PC write strobes (tied high when unused).
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
                o_ctrl.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ior_d    = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.ior_d     = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = 2'b10;
            end
            S_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = 2'b01;
                o_ctrl.pc_src        = 2'b01;
                o_ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter and sticky
// illegal-opcode flag. Define MC_CTRL_MEM_WAIT_EN to stall memory states on MemReady.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic [3:0]       State,
    output logic             Illegal,
    output logic [CNT_W-1:0] InsCount
);

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_ins_cnt;
    logic             w_mem_ready;
    logic             w_retire;
    logic             w_bad_op;
    ctrl_t            w_ctrl;
    logic             w_unused;

    // MemReady is a completion strobe: a memory state (FETCH, MEMRD, MEMWR)
    // holds until the cycle it is sampled high, then advances on that edge.
`ifdef MC_CTRL_MEM_WAIT_EN
    assign w_mem_ready = MemReady;
    assign w_unused    = Zero;
`else
    assign w_mem_ready = 1'b1;
    assign w_unused    = Zero ^ MemReady;
`endif

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_R_FORM:    w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_RWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    assign w_retire = is_terminal(r_state) && (w_next == S_FETCH);
    assign w_bad_op = (r_state == S_DECODE) && !op_known(Op);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_ins_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_bad_op)
                r_illegal <= 1'b1;
            if (w_retire)
                r_ins_cnt <= r_ins_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (w_mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.ior_d;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign RegDst      = w_ctrl.reg_dst;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSrc       = w_ctrl.pc_src;
    assign State       = r_state;
    assign Illegal     = r_illegal;
    assign InsCount    = r_ins_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, hand sequences for
// reset / stall corners, and randomized instructions against a path model.
module tb_mc_ctrl;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [5:0]    Op;
    logic          Zero;
    logic          MemReady;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB, ALUOp, PCSrc;
    logic [3:0]    State;
    logic          Illegal;
    logic [CW-1:0] InsCount;

    mc_ctrl #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .State(State), .Illegal(Illegal), .InsCount(InsCount)
    );

    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    int         mdl_cnt = 0;
    logic       mdl_ill = 1'b0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        zero;
        int          lat;
        logic [23:0] seq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] act_ctrl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc};
    endfunction

    // Expected controls for each state, written straight from the output lists.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic rdy);
        logic pcw, pcc, iord, mr, mw, irw, rd, m2r, rw, sa;
        logic [1:0] sb, ao, ps;
        {pcw, pcc, iord, mr, mw, irw, rd, m2r, rw, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            4'd0:  begin mr = 1; irw = rdy; pcw = rdy; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2, 4'd10: begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pcc = 1; end
            4'd9:  begin pcw = 1; ps = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pcw, pcc, iord, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps};
    endfunction

    function automatic logic model_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Instruction path as a list of state numbers (nibble i = i-th cycle).
    function automatic int model_path(input logic [5:0] op, output logic [23:0] seq);
        int st[$];
        st = '{0, 1};
        case (op)
            6'b000000: st = '{0, 1, 6, 7};
            6'b100011: st = '{0, 1, 2, 3, 4};
            6'b101011: st = '{0, 1, 2, 5};
            6'b000100: st = '{0, 1, 8};
            6'b000010: st = '{0, 1, 9};
            6'b001000: st = '{0, 1, 10, 11};
            default:   ;
        endcase
        seq = '0;
        foreach (st[i]) seq[4*i +: 4] = st[i][3:0];
        return st.size();
    endfunction

    task automatic drive_ready();
`ifdef MC_CTRL_MEM_WAIT_EN
        MemReady = 1'b1;
`else
        MemReady = 1'($urandom_range(0, 1));
`endif
    endtask

    // Runs one instruction starting in FETCH; checks every cycle against the model.
    task automatic exec_instr(input string name, input logic [5:0] op, input logic z,
                              input int lat, input logic [23:0] seq);
        logic       legal;
        logic [3:0] s;
        legal = model_legal(op);
        Op = op;
        Zero = z;
        drive_ready();
        for (int i = 0; i < lat; i++) exp_q.push_back(seq[4*i +: 4]);
        #1;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check({name, " state"}, 32'(State), 32'(s));
            check({name, " ctrl"}, 32'(act_ctrl()), 32'(exp_ctrl(s, 1'b1)));
            check({name, " illegal"}, 32'(Illegal), 32'(mdl_ill));
            check({name, " count"}, 32'(InsCount), 32'(mdl_cnt));
            @(posedge CLK);
            if (s == 4'd1 && !legal) mdl_ill = 1'b1;
            if (exp_q.size() == 0 && legal) mdl_cnt = (mdl_cnt + 1) % (1 << CW);
            @(negedge CLK);
            drive_ready();
            #1;
        end
        check({name, " back to fetch"}, 32'(State), 32'd0);
        check({name, " count after"}, 32'(InsCount), 32'(mdl_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [23:0] seq;
        logic [5:0]  op;
        int          lat;
        int          pick;
        logic [5:0]  legal_ops[6];

        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        vecs.push_back('{"rform", 6'b000000, 1'b0, 4, 24'h007610});
        vecs.push_back('{"lw",    6'b100011, 1'b0, 5, 24'h043210});
        vecs.push_back('{"sw",    6'b101011, 1'b1, 4, 24'h005210});
        vecs.push_back('{"beq_z1", 6'b000100, 1'b1, 3, 24'h000810});
        vecs.push_back('{"beq_z0", 6'b000100, 1'b0, 3, 24'h000810});
        vecs.push_back('{"j",     6'b000010, 1'b0, 3, 24'h000910});
        vecs.push_back('{"addi",  6'b001000, 1'b0, 4, 24'h00BA10});
        vecs.push_back('{"bad_op", 6'b111111, 1'b0, 2, 24'h000010});

        // Reset: FETCH outputs while held and on the first cycle after release.
        RST = 1'b0; Op = 6'b0; Zero = 1'b0; MemReady = 1'b1;
        #12;
        check("reset state", 32'(State), 32'd0);
        check("reset ctrl", 32'(act_ctrl()), 32'(exp_ctrl(4'd0, 1'b1)));
        check("reset illegal", 32'(Illegal), 32'd0);
        check("reset count", 32'(InsCount), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("post-reset ctrl", 32'(act_ctrl()), 32'(exp_ctrl(4'd0, 1'b1)));

        foreach (vecs[i]) exec_instr(vecs[i].name, vecs[i].op, vecs[i].zero, vecs[i].lat, vecs[i].seq);

        // Illegal must survive ten further legal instructions.
        for (int i = 0; i < 10; i++) begin
            lat = model_path(legal_ops[i % 6], seq);
            exec_instr("after_bad", legal_ops[i % 6], 1'($urandom_range(0, 1)), lat, seq);
        end
        check("illegal sticky", 32'(Illegal), 32'd1);

        // Asynchronous reset between edges while in MEMRD.
        Op = 6'b100011;
        repeat (3) @(negedge CLK);
        #1;
        check("pre-reset memrd", 32'(State), 32'd3);
        #2;
        RST = 1'b0;
        #1;
        check("async reset state", 32'(State), 32'd0);
        check("async reset count", 32'(InsCount), 32'd0);
        check("async reset illegal", 32'(Illegal), 32'd0);
        check("async reset ctrl", 32'(act_ctrl()), 32'(exp_ctrl(4'd0, 1'b1)));
        mdl_cnt = 0;
        mdl_ill = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        exec_instr("rform_first", 6'b000000, 1'b0, 4, 24'h007610);
        check("rform count one", 32'(InsCount), 32'd1);

`ifdef MC_CTRL_MEM_WAIT_EN
        // FETCH stalls while MemReady is low; IR/PC writes only on the ready cycle.
        Op = 6'b000010;
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall state", 32'(State), 32'd0);
            check("stall ctrl", 32'(act_ctrl()), 32'(exp_ctrl(4'd0, 1'b0)));
            @(negedge CLK);
        end
        MemReady = 1'b1;
        #1;
        check("ready ctrl", 32'(act_ctrl()), 32'(exp_ctrl(4'd0, 1'b1)));
        @(negedge CLK); #1;
        check("stall decode", 32'(State), 32'd1);
        @(negedge CLK); #1;
        check("stall jump", 32'(State), 32'd9);
        @(negedge CLK); #1;
        mdl_cnt = (mdl_cnt + 1) % (1 << CW);
        check("stall count", 32'(InsCount), 32'(mdl_cnt));
`endif

        // Random instruction stream; enough retirements to wrap the narrow counter.
        for (int i = 0; i < 60; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 7) op = legal_ops[$urandom_range(0, 5)];
            else          op = 6'($urandom_range(0, 63));
            lat = model_path(op, seq);
            exec_instr("random", op, 1'($urandom_range(0, 1)), lat, seq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
